// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// Request/ready handshake on the request side, rvalid/rdata on the response side.
interface if_stage_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;

  modport master (
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_ready,
    input  i_imem_rvalid,
    input  i_imem_rdata
  );

  modport slave (
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_ready,
    output i_imem_rvalid,
    output i_imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC, keeps exactly one instruction-memory request in flight, and
// loads the IF/ID register. Branch redirects flush wrong-path fetches and take
// priority over hazard stalls. Stalled responses are parked in a hold buffer.
// Optional feature: define IF_PERF_CNT_EN to add saturating stall/flush counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_no_change_pc,
  input  logic        i_no_change_IF_ID,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  if_stage_if.master  imem,
  output logic [31:0] o_IF_ID_Instr,
  output logic [31:0] o_IF_ID_PC4,
  output logic        o_IF_ID_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_flush_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        stall;
  logic        branch;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        deliver;
  logic [31:0] deliver_instr;

  assign stall    = i_no_change_pc | i_no_change_IF_ID;
  assign branch   = i_branch_taken;
  assign target   = i_branch_target & 32'hFFFF_FFFC;
  assign pc_plus4 = pc_q + 32'd4;

  // Fetch FSM: next state, PC update, hold buffer and instruction delivery
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d       = state_q;
    pc_d          = pc_q;
    hold_d        = hold_q;
    deliver       = 1'b0;
    deliver_instr = 32'h0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (branch) begin
          pc_d = target;
          // An accepted wrong-path request still returns data; drain it in DROP.
          if (imem.i_imem_ready) state_d = S_DROP;
        end else if (imem.i_imem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.i_imem_rvalid) begin
          if (branch) begin
            pc_d    = target;
            state_d = S_REQ;
          end else if (stall) begin
            hold_d  = imem.i_imem_rdata;
            state_d = S_HOLD;
          end else begin
            deliver       = 1'b1;
            deliver_instr = imem.i_imem_rdata;
            pc_d          = pc_plus4;
            state_d       = S_REQ;
          end
        end else if (branch) begin
          // Response still outstanding: redirect now, discard it when it lands.
          pc_d    = target;
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (branch) begin
          pc_d    = target;
          hold_d  = 32'h0;
          state_d = S_REQ;
        end else if (!stall) begin
          deliver       = 1'b1;
          deliver_instr = hold_q;
          pc_d          = pc_plus4;
          hold_d        = 32'h0;
          state_d       = S_REQ;
        end
      end
      S_DROP: begin
        if (branch) pc_d = target;
        if (imem.i_imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // IF/ID next value: new instruction, flush to bubble, hold on stall, else bubble
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (deliver) begin
      instr_d = deliver_instr;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end else if (branch || !stall) begin
      instr_d = 32'h0;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end
  end

  // State, PC, hold buffer and IF/ID registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      hold_q  <= 32'h0;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem.o_imem_req  = (state_q == S_REQ);
  assign imem.o_imem_addr = pc_q;
  assign o_IF_ID_Instr    = instr_q;
  assign o_IF_ID_PC4      = pc4_q;
  assign o_IF_ID_valid    = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  // Saturating counts of stalled cycles and branch-redirect cycles
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
    if (branch && (flush_count_q != 32'hFFFF_FFFF)) flush_count_d = flush_count_q + 32'd1;
  end

  // Performance counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cycles_q <= 32'h0;
      flush_count_q  <= 32'h0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign o_stall_cycles = stall_cycles_q;
  assign o_flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed timing scenarios plus a randomized
// run scored against an architectural model of the fetched instruction stream.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        no_change_pc = 1'b0;
  logic        no_change_if_id = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Instruction memory model state
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_wait = 0;
  int          lat_max = 1;
  bit          ready_rand = 1'b0;
  bit          force_en = 1'b0;
  logic [31:0] force_data = 32'h0;

  always #5 clk = ~clk;

  if_stage_if imem ();

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_no_change_pc    (no_change_pc),
    .i_no_change_IF_ID (no_change_if_id),
    .i_branch_taken    (branch_taken),
    .i_branch_target   (branch_target),
    .imem              (imem),
    .o_IF_ID_Instr     (if_id_instr),
    .o_IF_ID_PC4       (if_id_pc4),
    .o_IF_ID_valid     (if_id_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .o_stall_cycles    (stall_cycles),
    .o_flush_count     (flush_count)
`endif
  );

  // Memory contents as a pure function of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Advance one clock; memory model accepts requests and returns responses
  task automatic tick();
    logic        acc;
    logic        busy;
    logic [31:0] acc_addr;
    acc      = imem.o_imem_req && imem.i_imem_ready;
    busy     = pend || imem.i_imem_rvalid;
    acc_addr = imem.o_imem_addr;
    @(posedge clk);
    #1;
    imem.i_imem_rvalid = 1'b0;
    if (acc) begin
      vectors++;
      if (busy) begin
        miscompares++;
        $display("FAIL one_outstanding: request to %h accepted while response for %h still due", acc_addr, pend_addr);
      end
      pend      = 1'b1;
      pend_addr = acc_addr;
      pend_wait = (lat_max > 1) ? int'($urandom_range(0, lat_max - 1)) : 0;
    end
    if (pend) begin
      if (pend_wait == 0) begin
        imem.i_imem_rvalid = 1'b1;
        imem.i_imem_rdata  = force_en ? force_data : mem_word(pend_addr);
        pend               = 1'b0;
      end else begin
        pend_wait--;
      end
    end
    if (ready_rand) imem.i_imem_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic apply_reset();
    rst_n              = 1'b0;
    no_change_pc       = 1'b0;
    no_change_if_id    = 1'b0;
    branch_taken       = 1'b0;
    branch_target      = 32'h0;
    imem.i_imem_ready  = 1'b1;
    imem.i_imem_rvalid = 1'b0;
    imem.i_imem_rdata  = 32'h0;
    pend               = 1'b0;
    ready_rand         = 1'b0;
    lat_max            = 1;
    force_en           = 1'b0;
  endtask

  // Reset for two edges, release just after an edge: next edge is IDLE -> REQ
  task automatic do_reset();
    apply_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors += 5;
    if (imem.o_imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", imem.o_imem_req); end
    if (imem.o_imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 00000000", imem.o_imem_addr); end
    if (if_id_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 00000000", if_id_instr); end
    if (if_id_pc4 !== 32'h0) begin miscompares++; $display("FAIL reset_pc4: got %h want 00000000", if_id_pc4); end
    if (if_id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (imem.o_imem_req !== 1'b0) begin miscompares++; $display("FAIL idle_req: got %b want 0", imem.o_imem_req); end
    tick();
    vectors += 2;
    if (imem.o_imem_req !== 1'b1) begin miscompares++; $display("FAIL first_req: got %b want 1", imem.o_imem_req); end
    if (imem.o_imem_addr !== 32'h0) begin miscompares++; $display("FAIL first_addr: got %h want 00000000", imem.o_imem_addr); end
  endtask

  // Zero-wait memory: request every 2nd cycle, IF/ID valid every 2nd cycle
  task automatic test_sequential();
    logic exp_req;
    logic exp_valid;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      tick();
      exp_req   = (k % 2 == 0);
      exp_valid = (k >= 2) && (k % 2 == 0);
      vectors += 2;
      if (imem.o_imem_req !== exp_req) begin miscompares++; $display("FAIL seq_req k=%0d: got %b want %b", k, imem.o_imem_req, exp_req); end
      if (if_id_valid !== exp_valid) begin miscompares++; $display("FAIL seq_valid k=%0d: got %b want %b", k, if_id_valid, exp_valid); end
      if (exp_req) begin
        vectors++;
        if (imem.o_imem_addr !== 32'(2 * k)) begin miscompares++; $display("FAIL seq_addr k=%0d: got %h want %h", k, imem.o_imem_addr, 32'(2 * k)); end
      end
      if (exp_valid) begin
        vectors += 2;
        if (if_id_pc4 !== 32'(2 * k)) begin miscompares++; $display("FAIL seq_pc4 k=%0d: got %h want %h", k, if_id_pc4, 32'(2 * k)); end
        if (if_id_instr !== mem_word(32'(2 * k - 4))) begin miscompares++; $display("FAIL seq_instr k=%0d: got %h want %h", k, if_id_instr, mem_word(32'(2 * k - 4))); end
      end
    end
  endtask

  // Stall across the response: IF/ID keeps the older instruction, then releases the held one
  task automatic test_stall_hold();
    do_reset();
    repeat (3) tick();
    no_change_if_id = 1'b1;
    force_en        = 1'b1;
    force_data      = 32'h8C01_0004;
    for (int k = 3; k < 6; k++) begin
      tick();
      vectors += 5;
      if (if_id_valid !== 1'b1) begin miscompares++; $display("FAIL hold_valid k=%0d: got %b want 1", k, if_id_valid); end
      if (if_id_instr !== mem_word(32'h0)) begin miscompares++; $display("FAIL hold_instr k=%0d: got %h want %h", k, if_id_instr, mem_word(32'h0)); end
      if (if_id_pc4 !== 32'h4) begin miscompares++; $display("FAIL hold_pc4 k=%0d: got %h want 00000004", k, if_id_pc4); end
      if (imem.o_imem_req !== 1'b0) begin miscompares++; $display("FAIL hold_req k=%0d: got %b want 0", k, imem.o_imem_req); end
      if (imem.o_imem_addr !== 32'h4) begin miscompares++; $display("FAIL hold_addr k=%0d: got %h want 00000004", k, imem.o_imem_addr); end
    end
    no_change_if_id = 1'b0;
    tick();
    force_en = 1'b0;
    vectors += 4;
    if (if_id_instr !== 32'h8C01_0004) begin miscompares++; $display("FAIL release_instr: got %h want 8c010004", if_id_instr); end
    if (if_id_pc4 !== 32'h8) begin miscompares++; $display("FAIL release_pc4: got %h want 00000008", if_id_pc4); end
    if (if_id_valid !== 1'b1) begin miscompares++; $display("FAIL release_valid: got %b want 1", if_id_valid); end
    if (imem.o_imem_addr !== 32'h8) begin miscompares++; $display("FAIL release_addr: got %h want 00000008", imem.o_imem_addr); end
    tick();
    vectors++;
    if (imem.o_imem_addr !== 32'h8) begin miscompares++; $display("FAIL release_pc_once: got %h want 00000008", imem.o_imem_addr); end
  endtask

  // Branch in WAIT while rvalid arrives: data discarded, target fetched next
  task automatic test_branch_wait();
    do_reset();
    repeat (2) tick();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0103;
    tick();
    branch_taken = 1'b0;
    vectors += 4;
    if (if_id_valid !== 1'b0) begin miscompares++; $display("FAIL bw_valid: got %b want 0", if_id_valid); end
    if (if_id_instr !== 32'h0) begin miscompares++; $display("FAIL bw_instr: got %h want 00000000", if_id_instr); end
    if (imem.o_imem_req !== 1'b1) begin miscompares++; $display("FAIL bw_req: got %b want 1", imem.o_imem_req); end
    if (imem.o_imem_addr !== 32'h100) begin miscompares++; $display("FAIL bw_addr: got %h want 00000100", imem.o_imem_addr); end
    repeat (2) tick();
    vectors += 2;
    if (if_id_instr !== mem_word(32'h100)) begin miscompares++; $display("FAIL bw_target_instr: got %h want %h", if_id_instr, mem_word(32'h100)); end
    if (if_id_pc4 !== 32'h104) begin miscompares++; $display("FAIL bw_target_pc4: got %h want 00000104", if_id_pc4); end
  endtask

  // Branch in REQ with ready: the wrong-path response is drained and never delivered
  task automatic test_branch_drop();
    do_reset();
    tick();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0100;
    tick();
    branch_taken = 1'b0;
    vectors += 2;
    if (imem.o_imem_req !== 1'b0) begin miscompares++; $display("FAIL drop_req: got %b want 0", imem.o_imem_req); end
    if (imem.o_imem_addr !== 32'h100) begin miscompares++; $display("FAIL drop_addr: got %h want 00000100", imem.o_imem_addr); end
    for (int k = 1; k < 4; k++) begin
      vectors++;
      if (if_id_valid !== 1'b0) begin miscompares++; $display("FAIL drop_no_wrong_path k=%0d: got %b want 0", k, if_id_valid); end
      if (k == 2) begin
        vectors += 2;
        if (imem.o_imem_req !== 1'b1) begin miscompares++; $display("FAIL drop_refetch_req: got %b want 1", imem.o_imem_req); end
        if (imem.o_imem_addr !== 32'h100) begin miscompares++; $display("FAIL drop_refetch_addr: got %h want 00000100", imem.o_imem_addr); end
      end
      tick();
    end
    vectors += 2;
    if (if_id_valid !== 1'b1) begin miscompares++; $display("FAIL drop_target_valid: got %b want 1", if_id_valid); end
    if (if_id_instr !== mem_word(32'h100)) begin miscompares++; $display("FAIL drop_target_instr: got %h want %h", if_id_instr, mem_word(32'h100)); end
  endtask

  // Branch and stall together: flush wins over hold
  task automatic test_branch_stall();
    do_reset();
    repeat (3) tick();
    no_change_pc  = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0200;
    tick();
    no_change_pc = 1'b0;
    branch_taken = 1'b0;
    vectors += 4;
    if (if_id_valid !== 1'b0) begin miscompares++; $display("FAIL bs_valid: got %b want 0", if_id_valid); end
    if (if_id_instr !== 32'h0) begin miscompares++; $display("FAIL bs_instr: got %h want 00000000", if_id_instr); end
    if (if_id_pc4 !== 32'h0) begin miscompares++; $display("FAIL bs_pc4: got %h want 00000000", if_id_pc4); end
    if (imem.o_imem_addr !== 32'h200) begin miscompares++; $display("FAIL bs_pc: got %h want 00000200", imem.o_imem_addr); end
    tick();
    vectors++;
    if (imem.o_imem_req !== 1'b1 || imem.o_imem_addr !== 32'h200) begin
      miscompares++; $display("FAIL bs_refetch: got req=%b addr=%h want req=1 addr=00000200", imem.o_imem_req, imem.o_imem_addr);
    end
  endtask

  // Fetch at the top of memory: PC+4 wraps to zero
  task automatic test_wrap();
    do_reset();
    tick();
    imem.i_imem_ready = 1'b0;
    branch_taken      = 1'b1;
    branch_target     = 32'hFFFF_FFFC;
    tick();
    branch_taken      = 1'b0;
    imem.i_imem_ready = 1'b1;
    vectors++;
    if (imem.o_imem_req !== 1'b1 || imem.o_imem_addr !== 32'hFFFF_FFFC) begin
      miscompares++; $display("FAIL wrap_req: got req=%b addr=%h want req=1 addr=fffffffc", imem.o_imem_req, imem.o_imem_addr);
    end
    repeat (2) tick();
    vectors += 3;
    if (if_id_pc4 !== 32'h0 || if_id_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_pc4: got pc4=%h valid=%b want pc4=00000000 valid=1", if_id_pc4, if_id_valid); end
    if (if_id_instr !== mem_word(32'hFFFF_FFFC)) begin miscompares++; $display("FAIL wrap_instr: got %h want %h", if_id_instr, mem_word(32'hFFFF_FFFC)); end
    if (imem.o_imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_next_addr: got %h want 00000000", imem.o_imem_addr); end
  endtask

  // Asynchronous reset in WAIT with IF/ID loaded, then stray rvalid ignored
  task automatic test_reset_mid();
    do_reset();
    repeat (3) tick();
    no_change_if_id = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    vectors += 5;
    if (imem.o_imem_req !== 1'b0) begin miscompares++; $display("FAIL async_req: got %b want 0", imem.o_imem_req); end
    if (imem.o_imem_addr !== 32'h0) begin miscompares++; $display("FAIL async_addr: got %h want 00000000", imem.o_imem_addr); end
    if (if_id_instr !== 32'h0) begin miscompares++; $display("FAIL async_instr: got %h want 00000000", if_id_instr); end
    if (if_id_pc4 !== 32'h0) begin miscompares++; $display("FAIL async_pc4: got %h want 00000000", if_id_pc4); end
    if (if_id_valid !== 1'b0) begin miscompares++; $display("FAIL async_valid: got %b want 0", if_id_valid); end
    no_change_if_id    = 1'b0;
    pend               = 1'b0;
    imem.i_imem_ready  = 1'b0;
    imem.i_imem_rvalid = 1'b1;
    imem.i_imem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      imem.i_imem_rvalid = 1'b1;
      vectors += 2;
      if (if_id_valid !== 1'b0) begin miscompares++; $display("FAIL stray_valid k=%0d: got %b want 0", k, if_id_valid); end
      if (imem.o_imem_req !== 1'b1 || imem.o_imem_addr !== 32'h0) begin
        miscompares++; $display("FAIL stray_req k=%0d: got req=%b addr=%h want req=1 addr=00000000", k, imem.o_imem_req, imem.o_imem_addr);
      end
    end
    imem.i_imem_rvalid = 1'b0;
    imem.i_imem_ready  = 1'b1;
    repeat (2) tick();
    vectors++;
    if (if_id_valid !== 1'b1 || if_id_instr !== mem_word(32'h0) || if_id_pc4 !== 32'h4) begin
      miscompares++; $display("FAIL post_reset_fetch: got v=%b i=%h p=%h want v=1 i=%h p=00000004", if_id_valid, if_id_instr, if_id_pc4, mem_word(32'h0));
    end
  endtask

  // Random stalls, branches, ready and latency; every instruction ID consumes
  // must be the next one of the architectural fetch stream.
  task automatic test_random();
    logic [31:0] exp_addr;
    int          consumed;
    int          idle;
    int          stall_cnt;
    int          flush_cnt;
    logic        stall_now;
    do_reset();
    ready_rand = 1'b1;
    lat_max    = 3;
    exp_addr   = 32'h0;
    consumed   = 0;
    idle       = 0;
    stall_cnt  = 0;
    flush_cnt  = 0;
    tick();
    for (int c = 0; c < 4000; c++) begin
      no_change_pc    = ($urandom_range(0, 9) == 0);
      no_change_if_id = ($urandom_range(0, 5) == 0);
      branch_taken    = ($urandom_range(0, 15) == 0);
      branch_target   = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) branch_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      stall_now = no_change_pc | no_change_if_id;
      if (if_id_valid === 1'b1 && !stall_now && !branch_taken) begin
        vectors++;
        if (if_id_instr !== mem_word(exp_addr) || if_id_pc4 !== exp_addr + 32'd4) begin
          miscompares++;
          $display("FAIL rand_stream c=%0d: got instr=%h pc4=%h want instr=%h pc4=%h", c, if_id_instr, if_id_pc4, mem_word(exp_addr), exp_addr + 32'd4);
        end
        exp_addr = exp_addr + 32'd4;
        consumed++;
        idle = 0;
      end else begin
        idle++;
      end
      if (if_id_valid === 1'b0) begin
        vectors++;
        if (if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0) begin
          miscompares++; $display("FAIL rand_bubble c=%0d: got instr=%h pc4=%h want 0/0", c, if_id_instr, if_id_pc4);
        end
      end
      if (branch_taken) exp_addr = branch_target & 32'hFFFF_FFFC;
      if (idle > 300) begin
        miscompares++; $display("FAIL rand_watchdog c=%0d: no instruction consumed for %0d cycles", c, idle);
        break;
      end
      if (miscompares > 40) break;
      if (stall_now) stall_cnt++;
      if (branch_taken) flush_cnt++;
      tick();
    end
    vectors++;
    if (consumed < 200) begin miscompares++; $display("FAIL rand_throughput: got %0d instructions want at least 200", consumed); end
`ifdef IF_PERF_CNT_EN
    vectors += 2;
    if (stall_cycles !== 32'(stall_cnt)) begin miscompares++; $display("FAIL stall_counter: got %0d want %0d", stall_cycles, stall_cnt); end
    if (flush_count !== 32'(flush_cnt)) begin miscompares++; $display("FAIL flush_counter: got %0d want %0d", flush_count, flush_cnt); end
`endif
    ready_rand      = 1'b0;
    no_change_pc    = 1'b0;
    no_change_if_id = 1'b0;
    branch_taken    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_hold();
    test_branch_wait();
    test_branch_drop();
    test_branch_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule
